// File: rtl/loader_pkg.sv
// Shared types and header layout for the UART program loader.
// CHECK is only reachable when CHECKSUM_EN is defined.
package loader_pkg;

    localparam logic [1:0] ST_WAIT_HDR = 2'd0;
    localparam logic [1:0] ST_LOAD     = 2'd1;
    localparam logic [1:0] ST_CHECK    = 2'd2;
    localparam logic [1:0] ST_RUN      = 2'd3;

    typedef enum logic [1:0] {
        WAIT_HDR = ST_WAIT_HDR,
        LOAD     = ST_LOAD,
        CHECK    = ST_CHECK,
        RUN      = ST_RUN
    } state_e;

    localparam logic [15:0] LOADER_MAGIC = 16'hB007;

    localparam int MAGIC_MSB = 31;
    localparam int MAGIC_LSB = 16;
    localparam int COUNT_MSB = 15;
    localparam int COUNT_LSB = 0;

    function automatic logic [15:0] hdr_magic(input logic [31:0] w);
        return w[MAGIC_MSB:MAGIC_LSB];
    endfunction

    function automatic logic [15:0] hdr_count(input logic [31:0] w);
        return w[COUNT_MSB:COUNT_LSB];
    endfunction

endpackage

// File: rtl/uart_prog_loader_if.sv
// Word stream in from the UART assembler, instruction-memory write port out.
// master = the loader, slave = the UART/memory side.
interface uart_prog_loader_if #(
    parameter int ADDR_W = 10
);
    logic [31:0]       word_in;
    logic              word_valid;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;

    modport master (
        input  word_in,
        input  word_valid,
        output mem_we,
        output mem_addr,
        output mem_wdata
    );

    modport slave (
        output word_in,
        output word_valid,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata
    );
endinterface

// File: rtl/uart_prog_loader.sv
// Loads a framed program image into instruction memory, holding the core in reset.
// Define CHECKSUM_EN to require a trailing sum-of-payload word before release.
module uart_prog_loader
    import loader_pkg::*;
#(
    parameter int                ADDR_W    = 10,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter logic [15:0]       MAGIC     = LOADER_MAGIC
) (
    input  logic                clk,
    input  logic                reset,
    uart_prog_loader_if.master  bus,
    output logic                cpu_rst,
    output logic                busy,
    output logic                err
);

    localparam int CW = ADDR_W + 1;

    state_e            state_q, state_d;
    logic [CW-1:0]     count_q, count_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              we_q, we_d;
    logic              cpu_rst_q, cpu_rst_d;
    logic              busy_q, busy_d;
    logic              err_q, err_d;
    logic              armed_q, armed_d;
`ifdef CHECKSUM_EN
    logic [31:0]       sum_q, sum_d;
`endif

    logic        wv;
    logic [15:0] hdr_n;
    logic        hdr_ok;
    logic        take_hdr;

    // A pulse on the first edge after reset release is dropped.
    assign wv     = armed_q & bus.word_valid;
    assign hdr_n  = hdr_count(bus.word_in);
    assign hdr_ok = (hdr_magic(bus.word_in) == MAGIC) &&
                    (hdr_n != 16'd0) &&
                    (32'(hdr_n) <= (32'd1 << ADDR_W));
    assign take_hdr = wv && hdr_ok &&
                      (state_q == WAIT_HDR || state_q == RUN);

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        we_d      = 1'b0;
        cpu_rst_d = cpu_rst_q;
        busy_d    = busy_q;
        err_d     = err_q;
        armed_d   = 1'b1;
`ifdef CHECKSUM_EN
        sum_d     = sum_q;
`endif
        // Address advances in the cycle after each write.
        if (we_q)
            addr_d = addr_q + ADDR_W'(1);

        unique case (state_q)
            WAIT_HDR: begin
                cpu_rst_d = 1'b1;
                busy_d    = 1'b0;
                if (wv && !hdr_ok)
                    err_d = 1'b1;
            end
            LOAD: begin
                cpu_rst_d = 1'b1;
                if (wv) begin
                    wdata_d = bus.word_in;
                    we_d    = 1'b1;
                    count_d = count_q - CW'(1);
`ifdef CHECKSUM_EN
                    sum_d   = sum_q + bus.word_in;
                    if (count_q == CW'(1))
                        state_d = CHECK;
`else
                    if (count_q == CW'(1))
                        state_d = RUN;
`endif
                end
            end
`ifdef CHECKSUM_EN
            CHECK: begin
                cpu_rst_d = 1'b1;
                if (wv) begin
                    if (bus.word_in == sum_q) begin
                        state_d = RUN;
                    end else begin
                        err_d   = 1'b1;
                        busy_d  = 1'b0;
                        state_d = WAIT_HDR;
                    end
                end
            end
`endif
            RUN: begin
                cpu_rst_d = 1'b0;
                busy_d    = 1'b0;
            end
            default: begin
                state_d = WAIT_HDR;
            end
        endcase

        if (take_hdr) begin
            state_d   = LOAD;
            count_d   = CW'(hdr_n);
            addr_d    = BASE_ADDR;
            err_d     = 1'b0;
            busy_d    = 1'b1;
            cpu_rst_d = 1'b1;
`ifdef CHECKSUM_EN
            sum_d     = '0;
`endif
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= WAIT_HDR;
            count_q   <= '0;
            addr_q    <= BASE_ADDR;
            wdata_q   <= '0;
            we_q      <= 1'b0;
            cpu_rst_q <= 1'b1;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
            armed_q   <= 1'b0;
`ifdef CHECKSUM_EN
            sum_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            we_q      <= we_d;
            cpu_rst_q <= cpu_rst_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
            armed_q   <= armed_d;
`ifdef CHECKSUM_EN
            sum_q     <= sum_d;
`endif
        end
    end

    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign cpu_rst       = cpu_rst_q;
    assign busy          = busy_q;
    assign err           = err_q;

endmodule

// File: tb/tb_uart_prog_loader.sv
// Directed bench for uart_prog_loader (ADDR_W=4 instance).
// Build with CHECKSUM_EN defined to cover the checksum path as well.
module tb_uart_prog_loader;

    localparam int AW = 4;

    logic clk;
    logic reset;
    logic cpu_rst;
    logic busy;
    logic err;

    int errors = 0;
    int checks = 0;

    uart_prog_loader_if #(.ADDR_W(AW)) bus ();

    uart_prog_loader #(
        .ADDR_W   (AW),
        .BASE_ADDR(4'd0),
        .MAGIC    (16'hB007)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .bus    (bus.master),
        .cpu_rst(cpu_rst),
        .busy   (busy),
        .err    (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle pulse; returns 1ns after the edge that captured it.
    task automatic send(input logic [31:0] w);
        tick();
        bus.word_in    = w;
        bus.word_valid = 1'b1;
        tick();
        bus.word_valid = 1'b0;
    endtask

    task automatic send_sum(input logic [31:0] s);
`ifdef CHECKSUM_EN
        send(s);
`else
        if (s == 32'hFFFF_FFFF) tick();
`endif
    endtask

    task automatic chk_write(input string tag, input logic [31:0] a,
                             input logic [31:0] d);
        chk({tag, "_we"}, 32'(bus.mem_we), 32'd1);
        chk({tag, "_addr"}, 32'(bus.mem_addr), a);
        chk({tag, "_data"}, bus.mem_wdata, d);
    endtask

    initial begin
        logic [31:0] sum;
        bus.word_in    = '0;
        bus.word_valid = 1'b0;
        reset          = 1'b0;
        repeat (3) tick();

        chk("rst_we", 32'(bus.mem_we), 32'd0);
        chk("rst_addr", 32'(bus.mem_addr), 32'd0);
        chk("rst_wdata", bus.mem_wdata, 32'd0);
        chk("rst_cpu_rst", 32'(cpu_rst), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err), 32'd0);

        // Valid header pulsed across reset release must be dropped.
        bus.word_in    = 32'hB007_0001;
        bus.word_valid = 1'b1;
        reset          = 1'b1;
        tick();
        bus.word_valid = 1'b0;
        tick();
        chk("rel_ignored_busy", 32'(busy), 32'd0);

        // Basic 3-word frame.
        send(32'hB007_0003);
        chk("f3_hdr_busy", 32'(busy), 32'd1);
        chk("f3_hdr_we", 32'(bus.mem_we), 32'd0);
        chk("f3_hdr_err", 32'(err), 32'd0);
        send(32'h1111_1111);
        chk_write("f3_w0", 32'd0, 32'h1111_1111);
        send(32'h2222_2222);
        chk_write("f3_w1", 32'd1, 32'h2222_2222);
        send(32'h3333_3333);
        chk_write("f3_w2", 32'd2, 32'h3333_3333);
        chk("f3_last_cpu_rst", 32'(cpu_rst), 32'd1);
        send_sum(32'h6666_6666);
        chk("f3_hold_cpu_rst", 32'(cpu_rst), 32'd1);
        tick();
        chk("f3_cpu_rst", 32'(cpu_rst), 32'd0);
        chk("f3_busy", 32'(busy), 32'd0);
        chk("f3_err", 32'(err), 32'd0);
        chk("f3_we_off", 32'(bus.mem_we), 32'd0);

        // Reload from RUN.
        send(32'hB007_0001);
        chk("rl_cpu_rst", 32'(cpu_rst), 32'd1);
        chk("rl_busy", 32'(busy), 32'd1);
        send(32'hCAFE_BABE);
        chk_write("rl_w0", 32'd0, 32'hCAFE_BABE);
        send_sum(32'hCAFE_BABE);
        tick();
        chk("rl_cpu_rst_rel", 32'(cpu_rst), 32'd0);

        // Non-header and bad-magic words in RUN are ignored.
        send(32'h1234_5678);
        chk("run_ign_we", 32'(bus.mem_we), 32'd0);
        chk("run_ign_cpu_rst", 32'(cpu_rst), 32'd0);
        send(32'hDEAD_0002);
        chk("run_ign_err", 32'(err), 32'd0);
        chk("run_ign_busy", 32'(busy), 32'd0);

        // Reset after 2 of 4 payload words.
        send(32'hB007_0004);
        send(32'hAAAA_0001);
        send(32'hAAAA_0002);
        chk_write("mid_w1", 32'd1, 32'hAAAA_0002);
        reset = 1'b0;
        #1;
        chk("mid_rst_we", 32'(bus.mem_we), 32'd0);
        chk("mid_rst_addr", 32'(bus.mem_addr), 32'd0);
        chk("mid_rst_wdata", bus.mem_wdata, 32'd0);
        chk("mid_rst_cpu_rst", 32'(cpu_rst), 32'd1);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        tick();
        reset = 1'b1;
        tick();

        // Full frame after reset starts at BASE_ADDR.
        send(32'hB007_0004);
        sum = '0;
        for (int i = 0; i < 4; i++) begin
            send(32'hB000_0000 + 32'(i));
            sum += 32'hB000_0000 + 32'(i);
            chk_write("post_rst", 32'(i), 32'hB000_0000 + 32'(i));
        end
        send_sum(sum);
        tick();
        chk("post_rst_cpu_rst", 32'(cpu_rst), 32'd0);

        // Reset back to WAIT_HDR for framing errors.
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        send(32'hDEAD_0002);
        chk("bad_magic_err", 32'(err), 32'd1);
        chk("bad_magic_we", 32'(bus.mem_we), 32'd0);
        chk("bad_magic_cpu_rst", 32'(cpu_rst), 32'd1);
        chk("bad_magic_busy", 32'(busy), 32'd0);
        send(32'hB007_0000);
        chk("n0_err", 32'(err), 32'd1);
        chk("n0_busy", 32'(busy), 32'd0);
        send(32'hB007_0011);
        chk("n17_err", 32'(err), 32'd1);
        chk("n17_busy", 32'(busy), 32'd0);
        send(32'hB007_0001);
        chk("recov_err", 32'(err), 32'd0);
        chk("recov_busy", 32'(busy), 32'd1);
        send(32'h5555_5555);
        chk_write("recov_w0", 32'd0, 32'h5555_5555);
        send_sum(32'h5555_5555);
        tick();
        chk("recov_cpu_rst", 32'(cpu_rst), 32'd0);

        // Full-capacity frame, N = 2**AW.
        send(32'hB007_0010);
        chk("n16_busy", 32'(busy), 32'd1);
        sum = '0;
        for (int i = 0; i < 16; i++) begin
            send(32'h0100_0000 * 32'(i + 1) + 32'(i));
            sum += 32'h0100_0000 * 32'(i + 1) + 32'(i);
            chk_write("n16", 32'(i),
                      32'h0100_0000 * 32'(i + 1) + 32'(i));
        end
        chk("n16_last_cpu_rst", 32'(cpu_rst), 32'd1);
        send_sum(sum);
        tick();
        chk("n16_cpu_rst", 32'(cpu_rst), 32'd0);
        chk("n16_err", 32'(err), 32'd0);
        chk("n16_busy_off", 32'(busy), 32'd0);

`ifdef CHECKSUM_EN
        // Good checksum: 1+2+3 = 6.
        send(32'hB007_0003);
        send(32'd1);
        send(32'd2);
        send(32'd3);
        send(32'd6);
        chk("cs_ok_hold", 32'(cpu_rst), 32'd1);
        tick();
        chk("cs_ok_cpu_rst", 32'(cpu_rst), 32'd0);
        chk("cs_ok_err", 32'(err), 32'd0);

        // Bad checksum.
        send(32'hB007_0003);
        send(32'd1);
        send(32'd2);
        send(32'd3);
        send(32'd7);
        chk("cs_bad_err", 32'(err), 32'd1);
        chk("cs_bad_busy", 32'(busy), 32'd0);
        chk("cs_bad_cpu_rst", 32'(cpu_rst), 32'd1);
        tick();
        chk("cs_bad_cpu_rst2", 32'(cpu_rst), 32'd1);
        send(32'h1234_5678);
        chk("cs_bad_wait_we", 32'(bus.mem_we), 32'd0);
        chk("cs_bad_wait_err", 32'(err), 32'd1);
`endif

        repeat (2) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
